fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream drain stage for `sync_fifo`: pops words from the FIFO read port and transmits each word over a single-wire UART line as `data_width/8` consecutive 8N1 frames, least-significant byte first. It sits between the FIFO's read side (`rd_en`, `empty`, registered `data_out`) and the chip-level serial pin. The block owns FIFO pop timing and the baud timing. FIFO `cs` is driven at top level, not by this block.

## Interface
- `data_width`, default 32: FIFO word width. Must be a multiple of 8; elaboration error otherwise.
- `clks_per_bit`, default 16: clk cycles per UART bit. Must be ≥ 2; elaboration error otherwise.
- `clk` input, 1 bit: single clock, shared with `sync_fifo`.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: permits fetching new words. Does not abort a word already in progress.
- `fifo_empty` input, 1 bit: FIFO `empty`.
- `fifo_data` input, `data_width` bits: FIFO `data_out`, valid the cycle after a pop.
- `fifo_rd_en` output, 1 bit: FIFO pop request, one-cycle pulse.
- `tx` output, 1 bit: serial line, registered, idle high.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `word_done` output, 1 bit: one-cycle pulse on the last cycle of the last stop bit of a word.

## Operation
- **Reset values:** `tx`=1, `fifo_rd_en`=0, `busy`=0, `word_done`=0, state=IDLE, all counters 0.
- **States:**
  - IDLE → FETCH when `en && !fifo_empty`.
  - FETCH → LOAD, unconditionally.
  - LOAD → START, unconditionally. `fifo_data` is captured into the shift register at the end of LOAD.
  - START → DATA after `clks_per_bit` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if more bytes remain in the word; STOP → IDLE after the last byte.
- `fifo_rd_en` is a decode of FETCH only: exactly one pulse per word, never asserted while `fifo_empty` was sampled high.
- **Frame format:** start bit (0), 8 data bits LSB first, stop bit (1).
  - Word bytes go out in the order [7:0], [15:8], and so on up to the top byte.
- **Counters:**
  - Baud counter is `$clog2(clks_per_bit)` bits, counts 0…`clks_per_bit`-1 and wraps.
  - Bit counter is 3 bits.
  - Byte counter is `$clog2(data_width/8)` bits, minimum 1.
- **`en` deasserted mid-word:** the current word completes, then the block stays in IDLE.
- **Reset mid-word:** `tx` goes to 1 immediately (asynchronous). The partially sent word is lost; it has already been popped from the FIFO.
- **FIFO emptied mid-word:** no effect, since the word is already captured in the shift register.

## Timing
- Let cycle n be an IDLE cycle in which `en && !fifo_empty` is sampled.
  - `fifo_rd_en` is high in cycle n+1.
  - LOAD occupies cycle n+2.
  - `tx`=0 from cycle n+3.
- Each bit holds exactly `clks_per_bit` cycles.
- One frame is 10×`clks_per_bit` cycles.
- Bytes within a word are back-to-back: the stop bit is followed immediately by the next start bit, with no extra idle.
- **Word-to-word:** after the last stop bit, there is one IDLE cycle, then FETCH, then LOAD.
  - Minimum line-high gap between words is therefore `clks_per_bit`+3 cycles, counting the stop bit.
- `word_done` pulses in the final stop-bit cycle. `busy` falls on the next cycle.
- Throughput: one word per (data_width/8)×10×`clks_per_bit` + 3 cycles.

## Structure
- **Package `fifo_uart_pkg`:**
  - State enum, 3-bit encoding: IDLE, FETCH, LOAD, START, DATA, STOP.
  - Frame constants: 8 data bits, 1 start bit, 1 stop bit.
  - Idle line level constant (1).
- **Sub-module `baud_tick_gen`:**
  - Parameter `clks_per_bit`.
  - Inputs `clk`, `rst`, `clear`.
  - Output `tick`, high on the last cycle of each bit period.
  - `clear` is asserted on the transition into START.
- The FSM, shift register, and bit/byte counters live in `fifo_uart_tx`.

## Test plan
- **Single word:** `clks_per_bit`=4, FIFO holds 0xA5C30F81, `en`=1.
  - `fifo_rd_en` pulses exactly once.
  - `tx` shows frames for 0x81, 0x0F, 0xC3, 0xA5, LSB first, each 40 cycles long.
  - `word_done` pulses at cycle 160 after the first start-bit cycle.
- **Back-to-back:** FIFO holds 0x00000001 and 0xFFFFFFFE.
  - Second `fifo_rd_en` arrives 2 cycles after the first word's `word_done`.
  - Line-high gap between the words is 7 cycles.
  - `fifo_empty` is never violated.
- **Empty FIFO:** `fifo_empty`=1 for 100 cycles.
  - `fifo_rd_en`=0, `tx`=1, `busy`=0 throughout.
- **`en` dropped:** `en` goes low during byte 1 with 3 words queued.
  - The current word finishes; no further `fifo_rd_en`.
  - Re-asserting `en` resumes with word 2 intact.
- **Reset mid-DATA:** `rst`=0 mid-DATA.
  - `tx`=1 and `busy`=0 immediately, without waiting for a clock edge.
  - After release, the next queued word is sent from its first byte.
- **Non-default width:** `data_width`=8, `clks_per_bit`=2, FIFO holds 0x5A.
  - One 20-cycle frame reading 0,0,1,0,1,1,0,1,0,1.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: FSM state encoding, UART frame constants and counter sizing helper
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam int DATA_BITS  = 8;
    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width for n states; a single state still needs a 1-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read side plus serial/status signals of the UART drain stage
//   en, fifo_empty, fifo_data : inputs to the drain stage
//   fifo_rd_en, tx            : FIFO pop request and serial line
//   busy, word_done           : status
interface fifo_uart_tx_if #(
    parameter int data_width = 32
);

    logic                  en;
    logic                  fifo_empty;
    logic [data_width-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  word_done;

    modport master (
        output en, fifo_empty, fifo_data,
        input  fifo_rd_en, tx, busy, word_done
    );

    modport slave (
        input  en, fifo_empty, fifo_data,
        output fifo_rd_en, tx, busy, word_done
    );

endinterface

// File: rtl/fifo_uart_tx_baud.sv
// baud_tick_gen: free-running bit-period counter, restartable for frame alignment
//   clk, rst_n : clock, async active-low reset
//   clear_i    : restart the period so the next cycle is its first
//   tick_o     : high on the last cycle of each bit period
module baud_tick_gen #(
    parameter int clks_per_bit = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int W = $clog2(clks_per_bit);
    localparam logic [W-1:0] LAST = W'(clks_per_bit - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == LAST;
    assign cnt_d  = (clear_i || tick_o) ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO words and sends each as data_width/8 8N1 frames, LSB byte first
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of fifo_uart_tx_if (en, fifo_empty, fifo_data in;
//                fifo_rd_en, tx, busy, word_done out)
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int data_width   = 32,
    parameter int clks_per_bit = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_uart_tx_if.slave bus
);

    localparam int NBYTES = data_width / DATA_BITS;
    localparam int BYW    = cnt_width(NBYTES);
    localparam logic [BYW-1:0] LAST_BYTE = BYW'(NBYTES - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

    if (data_width <= 0 || data_width % DATA_BITS != 0) begin : g_bad_width
        $error("fifo_uart_tx: data_width must be a positive multiple of 8");
    end
    if (clks_per_bit < 2) begin : g_bad_cpb
        $error("fifo_uart_tx: clks_per_bit must be at least 2");
    end

    state_t                state_q, state_d;
    logic [data_width-1:0] shift_q, shift_d;
    logic [2:0]            bit_q, bit_d;
    logic [BYW-1:0]        byte_q, byte_d;
    logic                  tx_q, tx_d;
    logic                  tick, last_byte, clear;

    baud_tick_gen #(.clks_per_bit(clks_per_bit)) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(clear),
        .tick_o (tick)
    );

    assign last_byte = byte_q == LAST_BYTE;

    // The shift register moves one place per data bit, so after eight bits the
    // next byte of the word already sits in the low lane.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE:  state_d = (bus.en && !bus.fifo_empty) ? S_FETCH : S_IDLE;
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_START;
                shift_d = bus.fifo_data;
            end
            S_START: if (tick) begin
                state_d = S_DATA;
                bit_d   = '0;
            end
            S_DATA: if (tick) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == LAST_BIT) ? S_STOP : S_DATA;
            end
            S_STOP: if (tick) begin
                state_d = last_byte ? S_IDLE : S_START;
                byte_d  = last_byte ? '0 : byte_q + BYW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes together with the state.
    assign tx_d  = (state_d == S_START) ? 1'b0 :
                   (state_d == S_DATA)  ? shift_d[0] : IDLE_LEVEL;
    assign clear = (state_d == S_START) && (state_q != S_START);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.fifo_rd_en = state_q == S_FETCH;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.word_done  = (state_q == S_STOP) && tick && last_byte;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx (32-bit/4 clk and 8-bit/2 clk instances)
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int CPB_B = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, failures = 0, cyc = 0, rd_cnt = 0;

    logic [31:0] fq[$];
    logic [7:0]  fqb[$];
    logic [7:0]  exp_q[$];
    logic        expb[$];

    fifo_uart_tx_if #(.data_width(32)) a ();
    fifo_uart_tx_if #(.data_width(8))  b ();

    fifo_uart_tx #(.data_width(32), .clks_per_bit(CPB)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (a)
    );

    fifo_uart_tx #(.data_width(8), .clks_per_bit(CPB_B)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: registered data_out after a pop, registered empty flag.
    always @(posedge clk) begin
        if (a.fifo_rd_en && !a.fifo_empty) a.fifo_data <= fq.pop_front();
        a.fifo_empty <= fq.size() == 0;
        if (b.fifo_rd_en && !b.fifo_empty) b.fifo_data <= fqb.pop_front();
        b.fifo_empty <= fqb.size() == 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_a(input logic [31:0] w);
        fq.push_back(w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic push_b(input logic [7:0] w);
        logic [9:0] frame;
        fqb.push_back(w);
        frame = {1'b1, w, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int c = 0; c < CPB_B; c++) expb.push_back(frame[i]);
    endtask

    // 0: a.tx low, 1: a.word_done, 2: a.fifo_rd_en, 3: b.word_done
    task automatic wait_ev(input int which, output int t);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if ((which == 0 && a.tx === 1'b0) || (which == 1 && a.word_done === 1'b1) ||
                (which == 2 && a.fifo_rd_en === 1'b1) || (which == 3 && b.word_done === 1'b1)) begin
                t = cyc;
                return;
            end
        end
        t = -1;
        checks++;
        failures++;
        $display("FAIL timeout_%0d actual=no_event required=event", which);
    endtask

    // Receive one frame starting at the current (first start-bit) sample.
    task automatic rx_a();
        logic [9:0] f;
        int bad = 0;
        for (int i = 0; i < 10; i++)
            for (int c = 0; c < CPB; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (!rst_n) return;
                if (c == 0) f[i] = a.tx;
                else if (a.tx !== f[i]) bad++;
            end
        chk("frame_shape", {29'd0, bad == 0, f[0], f[9]}, 32'd5);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=%0h required=none", f[8:1]);
        end else chk("rx_byte", {24'd0, f[8:1]}, {24'd0, exp_q.pop_front()});
    endtask

    initial begin
        logic prev_a = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev_a && a.tx === 1'b0) rx_a();
            prev_a = a.tx;
            if (a.fifo_rd_en === 1'b1) begin
                rd_cnt++;
                chk("rd_while_empty", {31'd0, a.fifo_empty}, 32'd0);
            end
        end
    end

    initial begin
        logic prev_b = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev_b && b.tx === 1'b0)
                for (int i = 0; i < 10 * CPB_B; i++) begin
                    if (i != 0) @(negedge clk);
                    if (expb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL b_unexpected_bit actual=%b required=none", b.tx);
                    end else chk("b_line", {31'd0, b.tx}, {31'd0, expb.pop_front()});
                end
            prev_b = b.tx;
        end
    end

    initial begin
        int t0, t1, t2, r0, bad;
        a.en = 1'b0;
        b.en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, a.tx}, 32'd1);
        chk("rst_busy", {31'd0, a.busy}, 32'd0);
        chk("rst_rd_en", {31'd0, a.fifo_rd_en}, 32'd0);
        chk("rst_word_done", {31'd0, a.word_done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        a.en = 1'b1;
        b.en = 1'b1;

        r0 = rd_cnt;
        push_a(32'hA5C30F81);
        wait_ev(2, t0);
        wait_ev(0, t1);
        chk("rd_to_start", t1 - t0, 32'd2);
        wait_ev(1, t2);
        chk("word_len", t2 - t1, 32'd159);
        chk("busy_at_done", {31'd0, a.busy}, 32'd1);
        @(negedge clk);
        chk("busy_after_done", {31'd0, a.busy}, 32'd0);
        chk("single_rd_count", rd_cnt - r0, 32'd1);

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (a.fifo_rd_en !== 1'b0 || a.tx !== 1'b1 || a.busy !== 1'b0) bad++;
        end
        chk("empty_idle", bad, 32'd0);

        push_a(32'h00000001);
        push_a(32'hFFFFFFFE);
        wait_ev(1, t0);
        wait_ev(2, t1);
        chk("b2b_rd_gap", t1 - t0, 32'd2);
        wait_ev(0, t2);
        chk("b2b_line_gap", t2 - t0 + CPB - 1, 32'd7);
        wait_ev(1, t0);

        r0 = rd_cnt;
        push_a(32'h11223344);
        push_a(32'h55667788);
        push_a(32'h99AABBCC);
        wait_ev(0, t0);
        repeat (50) @(negedge clk);
        a.en = 1'b0;
        wait_ev(1, t1);
        repeat (60) @(negedge clk);
        chk("en_low_rd_count", rd_cnt - r0, 32'd1);
        chk("en_low_busy", {31'd0, a.busy}, 32'd0);
        chk("en_low_tx", {31'd0, a.tx}, 32'd1);
        a.en = 1'b1;
        wait_ev(1, t1);
        wait_ev(1, t1);
        chk("en_resume_rd_count", rd_cnt - r0, 32'd3);

        push_a(32'hDEADBEEF);
        push_a(32'h0BADF00D);
        wait_ev(0, t0);
        repeat (21) @(negedge clk);
        chk("pre_rst_tx_low", {31'd0, a.tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, a.tx}, 32'd1);
        chk("async_rst_busy", {31'd0, a.busy}, 32'd0);
        repeat (4) void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ev(1, t0);

        push_b(8'h5A);
        wait_ev(3, t0);

        repeat (5) @(negedge clk);
        chk("sb_drained_a", exp_q.size(), 32'd0);
        chk("sb_drained_b", expb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
